uart_rx_core: RTL and testbench

UART receive engine that sits directly behind the `rx` input pad and inside `risc_v_top`. It takes the raw serial line from the pad (asynchronous to `clk`) and runs it through a two-flop synchronizer. It then deframes 8N1 characters (8E1 when parity is compiled in) by mid-bit sampling. Each received byte goes to the core through a one-entry valid/ready holding register, with sticky error flags.

---
 rtl/uart_rx_core.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop synchronizer, mid-bit sampling 8N1 deframer and a
// one-entry valid/ready holding register with sticky errors. Define UART_RX_PARITY_EN for 8E1.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  input  logic       err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_err_q, overrun_err_d;
  logic            cnt_zero, deliver, load, frame_set, overrun_set;
`ifdef UART_RX_PARITY_EN
  logic            parity_err_q, parity_err_d;
  logic            parity_set;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    deliver   = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set = 1'b0;
`endif
    cnt_zero  = (bit_cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          bit_cnt_d = HALF_M1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (!cnt_zero) begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end else if (sync2_q) begin
          state_d = S_IDLE;
        end else begin
          bit_cnt_d = FULL_M1;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (!cnt_zero) begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end else begin
          shreg_d   = {sync2_q, shreg_q[7:1]};
          bit_cnt_d = FULL_M1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!cnt_zero) begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end else begin
          // Even parity: data plus parity bit must hold an even number of ones.
          parity_set = ^{shreg_q, sync2_q};
          bit_cnt_d  = FULL_M1;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!cnt_zero) begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end else if (sync2_q) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_set = 1'b1;
          state_d   = S_BREAK;
        end
      end
      S_BREAK: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A same-cycle read frees the holding register for the new byte.
    load        = deliver && (!rx_valid_q || rx_ready);
    overrun_set = deliver && rx_valid_q && !rx_ready;
    rx_data_d   = load ? shreg_q : rx_data_q;
    if (load)                          rx_valid_d = 1'b1;
    else if (rx_valid_q && rx_ready)   rx_valid_d = 1'b0;
    else                               rx_valid_d = rx_valid_q;

    frame_err_d   = frame_set   ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overrun_err_d = overrun_set ? 1'b1 : (err_clr ? 1'b0 : overrun_err_q);
`ifdef UART_RX_PARITY_EN
    parity_err_d  = parity_set  ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      bit_cnt_q     <= '0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= rx;
      sync2_q       <= sync1_q;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLKS_PER_BIT = 16; honours UART_RX_PARITY_EN.
module tb_uart_rx_core;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
  localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

  logic       clk = 1'b0;
  logic       rst, rx, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int mark     = 0;
  int base_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err),
    .parity_err(parity_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every rising edge of rx_valid together with the byte presented.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cnt  = rise_cnt + 1;
      rise_cyc  = cyc;
      last_data = rx_data;
      $display("rx byte 0x%02h at cycle %0d", rx_data, cyc);
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
  endtask

  // Start bit, eight data bits LSB first, optional parity, stop bit; line is left at stop_v.
  task automatic send_frame(input logic [7:0] d, input logic par_v, input logic stop_v);
    @(posedge clk);
    #1;
    rx   = 1'b0;
    mark = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_v;
    wait_cycles(CPB);
`else
    if (par_v === 1'bx) $display("unused parity bit");
`endif
    rx = stop_v;
    wait_cycles(CPB);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    wait_cycles(3);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_flags", {29'd0, frame_err, overrun_err, parity_err}, 32'h0);
    rst = 1'b0;
    wait_cycles(4);

    // Single frame with exact pin-to-valid latency.
    rx_ready = 1'b1;
    base_cnt = rise_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_cycles(4);
    check("a5_count", 32'(rise_cnt - base_cnt), 32'd1);
    check("a5_latency", 32'(rise_cyc - mark), 32'(EXP_LAT));
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_valid_consumed", 32'(rx_valid), 32'h0);
    check("a5_flags", {29'd0, frame_err, overrun_err, parity_err}, 32'h0);

    // Short low glitch must be rejected silently.
    base_cnt = rise_cnt;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(3 * CPB);
    check("glitch_no_valid", 32'(rise_cnt - base_cnt), 32'd0);
    check("glitch_flags", {29'd0, frame_err, overrun_err, parity_err}, 32'h0);

    // Back-to-back frames with no reader: second byte overruns.
    rx_ready = 1'b0;
    base_cnt = rise_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_cycles(4);
    check("ovr_count", 32'(rise_cnt - base_cnt), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h3C);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_flag", 32'(overrun_err), 32'h1);
    check("ovr_frame_flag", 32'(frame_err), 32'h0);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    wait_cycles(1);
    check("ovr_consumed", 32'(rx_valid), 32'h0);
    check("ovr_data_hold", 32'(rx_data), 32'h3C);
    check("ovr_sticky", 32'(overrun_err), 32'h1);
    pulse_clr();
    wait_cycles(1);
    check("ovr_cleared", 32'(overrun_err), 32'h0);

    // Low stop bit followed by a held-low line: one frame error, no repeat frames.
    rx_ready = 1'b1;
    base_cnt = rise_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    check("brk_frame_err", 32'(frame_err), 32'h1);
    wait_cycles(5 * CPB);
    pulse_clr();
    wait_cycles(35 * CPB);
    check("brk_no_repeat", 32'(frame_err), 32'h0);
    check("brk_no_valid", 32'(rise_cnt - base_cnt), 32'd0);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_cycles(4);
    check("brk_recover_count", 32'(rise_cnt - base_cnt), 32'd1);
    check("brk_recover_data", 32'(last_data), 32'h81);

    // Reset in the middle of data bit 4 of 0xFF.
    base_cnt = rise_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(4 * CPB + CPB / 2);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(6 * CPB);
    check("rst_no_valid", 32'(rise_cnt - base_cnt), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_flags", {29'd0, frame_err, overrun_err, parity_err}, 32'h0);
    send_frame(8'h12, 1'b0, 1'b1);
    wait_cycles(4);
    check("rst_after_count", 32'(rise_cnt - base_cnt), 32'd1);
    check("rst_after_data", 32'(last_data), 32'h12);
    check("rst_after_flags", {29'd0, frame_err, overrun_err, parity_err}, 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs 1; send 0.
    rx_ready = 1'b0;
    base_cnt = rise_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    wait_cycles(4);
    check("par_data", 32'(rx_data), 32'h07);
    check("par_valid", 32'(rx_valid), 32'h1);
    check("par_err", 32'(parity_err), 32'h1);
    check("par_frame_ok", 32'(frame_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
